// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS encodings for the branch/PC unit: opcode, funct
//                and REGIMM rt constants, branch_conditions bit indices,
//                control state encoding and the branch offset helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_REGIMM  = 6'b000001;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_BNE     = 6'b000101;
    localparam logic [5:0] c_OP_BLEZ    = 6'b000110;
    localparam logic [5:0] c_OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] c_FUNCT_JR   = 6'b001000;
    localparam logic [5:0] c_FUNCT_JALR = 6'b001001;

    // REGIMM sub-ops carried in the rt field
    localparam logic [4:0] c_RT_BLTZ    = 5'b00000;
    localparam logic [4:0] c_RT_BGEZ    = 5'b00001;
    localparam logic [4:0] c_RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] c_RT_BGEZAL  = 5'b10001;

    // Link register for the implicit-link forms
    localparam logic [4:0] c_LINK_RA    = 5'd31;

    // branch_conditions bit positions produced by the ALU
    localparam int BC_NEG  = 0;  // rs < 0 (signed)
    localparam int BC_ZERO = 1;  // rs == 0
    localparam int BC_POS  = 2;  // rs > 0 (signed)
    localparam int BC_EQ   = 3;  // rs == rt

    // Control state encoding
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DELAY = 2'd1,
        HALT  = 2'd2
    } state_e;

    // Word offset of a conditional branch: sign-extended imm16 scaled by 4
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_eval
//  Description : Purely combinational decode of one instruction: whether it
//                redirects control flow, whether it writes a link register
//                (and which one), and the resolved target address.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] op1,
    input  logic [3:0]  branch_conditions,
    output logic        taken,
    output logic        link,
    output logic [4:0]  link_reg,
    output logic [31:0] target
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    assign w_pc_plus4      = pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + branch_offset(imm16);
    assign w_jump_target   = {w_pc_plus4[31:28], index26, 2'b00};

    // Decode taken/link/target; link on the AL forms does not depend on taken
    always_comb begin
        taken    = 1'b0;
        link     = 1'b0;
        link_reg = c_LINK_RA;
        target   = w_branch_target;
        case (opcode)
            c_OP_BEQ:  taken = branch_conditions[BC_EQ];
            c_OP_BNE:  taken = ~branch_conditions[BC_EQ];
            c_OP_BLEZ: taken = branch_conditions[BC_NEG] | branch_conditions[BC_ZERO];
            c_OP_BGTZ: taken = branch_conditions[BC_POS];
            c_OP_REGIMM: begin
                case (rt)
                    c_RT_BLTZ:   taken = branch_conditions[BC_NEG];
                    c_RT_BLTZAL: begin
                        taken = branch_conditions[BC_NEG];
                        link  = 1'b1;
                    end
                    c_RT_BGEZ:   taken = branch_conditions[BC_ZERO] | branch_conditions[BC_POS];
                    c_RT_BGEZAL: begin
                        taken = branch_conditions[BC_ZERO] | branch_conditions[BC_POS];
                        link  = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_OP_J: begin
                taken  = 1'b1;
                target = w_jump_target;
            end
            c_OP_JAL: begin
                taken  = 1'b1;
                link   = 1'b1;
                target = w_jump_target;
            end
            c_OP_SPECIAL: begin
                if (funct == c_FUNCT_JR) begin
                    taken  = 1'b1;
                    target = op1;
                end else if (funct == c_FUNCT_JALR) begin
                    taken    = 1'b1;
                    link     = 1'b1;
                    link_reg = rd;
                    target   = op1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pc_unit
//  Description : Owns the architectural PC and the single branch-delay slot.
//                Taken branches/jumps load a target register and execute one
//                delay-slot instruction before the redirect; a jump to
//                HALT_ADDR stops the CPU until reset.
//                Optional macro BRANCH_ALIGN_CHECK_EN: a misaligned resolved
//                target raises sticky addr_err and halts at the delay slot
//                instead of redirecting.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        instr_valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] op1,
    input  logic [3:0]  branch_conditions,
    output logic [31:0] pc,
    output logic        link_en,
    output logic [4:0]  link_reg,
    output logic [31:0] link_data,
    output logic        taken,
    output logic        active,
    output logic        addr_err
);

    localparam logic [1:0] c_ST_RUN   = RUN;
    localparam logic [1:0] c_ST_DELAY = DELAY;
    localparam logic [1:0] c_ST_HALT  = HALT;

    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [1:0]  r_state;
    logic        r_active;
    logic        r_addr_err;

    logic        w_accept;
    logic        w_in_run;
    logic        w_cond_taken;
    logic        w_cond_link;
    logic [4:0]  w_cond_link_reg;
    logic [31:0] w_cond_target;
    logic        w_misaligned;

    branch_cond_eval u_eval (
        .pc                (r_pc),
        .opcode            (opcode),
        .funct             (funct),
        .rt                (rt),
        .rd                (rd),
        .imm16             (imm16),
        .index26           (index26),
        .op1               (op1),
        .branch_conditions (branch_conditions),
        .taken             (w_cond_taken),
        .link              (w_cond_link),
        .link_reg          (w_cond_link_reg),
        .target            (w_cond_target)
    );

    assign w_accept     = instr_valid & ~stall & (r_state != c_ST_HALT);
    assign w_in_run     = (r_state == c_ST_RUN);
    assign w_misaligned = (w_cond_target[1:0] != 2'b00);

    // A control-flow instruction sitting in the delay slot is ignored
    assign taken     = w_accept & w_in_run & w_cond_taken;
    assign link_en   = w_accept & w_in_run & w_cond_link;
    assign link_reg  = w_cond_link_reg;
    assign link_data = r_pc + 32'd8;
    assign pc        = r_pc;
    assign active    = r_active;
    assign addr_err  = r_addr_err;

    // PC, delay-slot target and run/halt state advance only on an accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_target   <= 32'd0;
            r_state    <= c_ST_RUN;
            r_active   <= 1'b1;
            r_addr_err <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                c_ST_RUN: begin
                    r_pc <= r_pc + 32'd4;
                    if (w_cond_taken) begin
                        r_target <= w_cond_target;
                        r_state  <= c_ST_DELAY;
`ifdef BRANCH_ALIGN_CHECK_EN
                        if (w_misaligned) begin
                            r_addr_err <= 1'b1;
                        end
`endif
                    end
                end
                c_ST_DELAY: begin
`ifdef BRANCH_ALIGN_CHECK_EN
                    if (r_addr_err) begin
                        // Stop on the delay-slot pc rather than jump to a bad target
                        r_state  <= c_ST_HALT;
                        r_active <= 1'b0;
                    end else
`endif
                    begin
                        r_pc <= r_target;
                        if (r_target == HALT_ADDR) begin
                            r_state  <= c_ST_HALT;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef BRANCH_ALIGN_CHECK_EN
    // Alignment status is unused when the check is compiled out
    logic w_unused;
    assign w_unused = w_misaligned;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_pc_unit
//  Description : Directed self-checking bench for branch_pc_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] op1;
    logic [3:0]  branch_conditions;
    logic [31:0] pc;
    logic        link_en;
    logic [4:0]  link_reg;
    logic [31:0] link_data;
    logic        taken;
    logic        active;
    logic        addr_err;

    int n_checks;
    int n_fail;

    branch_pc_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .instr_valid       (instr_valid),
        .opcode            (opcode),
        .funct             (funct),
        .rt                (rt),
        .rd                (rd),
        .imm16             (imm16),
        .index26           (index26),
        .op1               (op1),
        .branch_conditions (branch_conditions),
        .pc                (pc),
        .link_en           (link_en),
        .link_reg          (link_reg),
        .link_data         (link_data),
        .taken             (taken),
        .active            (active),
        .addr_err          (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present an instruction; inputs change 1 time unit after a rising edge
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rti,
                         input logic [4:0] rdi, input logic [15:0] im, input logic [25:0] idx,
                         input logic [31:0] o1, input logic [3:0] bc);
        opcode = op; funct = fn; rt = rti; rd = rdi; imm16 = im;
        index26 = idx; op1 = o1; branch_conditions = bc;
    endtask

    // ADDI-style non-control instruction
    task automatic drive_nop();
        drive(6'b001000, 6'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 4'd0);
    endtask

    // Advance one clock, leaving us 1 unit past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        instr_valid = 1'b0;
        drive_nop();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        instr_valid = 1'b0;
        stall = 1'b0;
        reset = 1'b0;
        drive_nop();
        #2;
        do_reset();

        // Reset state
        check("rst_pc", pc, 32'hBFC00000);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_link_en", {31'd0, link_en}, 32'd0);

        // Sequential fetch
        instr_valid = 1'b1;
        drive_nop();
        check("seq_taken", {31'd0, taken}, 32'd0);
        step(); check("seq_pc1", pc, 32'hBFC00004);
        step(); check("seq_pc2", pc, 32'hBFC00008);
        step(); check("seq_pc3", pc, 32'hBFC0000C);
        check("seq_active", {31'd0, active}, 32'd1);

        // Without accept nothing moves
        instr_valid = 1'b0;
        step(); check("noacc_pc", pc, 32'hBFC0000C);

        // BEQ taken from reset vector, target BFC00010
        do_reset();
        instr_valid = 1'b1;
        drive(6'b000100, 6'd0, 5'd0, 5'd0, 16'h0003, 26'd0, 32'd0, 4'b1000);
        #1; check("beq_taken", {31'd0, taken}, 32'd1);
        check("beq_link_en", {31'd0, link_en}, 32'd0);
        step(); check("beq_delay_pc", pc, 32'hBFC00004);
        drive_nop();
        step(); check("beq_target_pc", pc, 32'hBFC00010);

        // BNE with equal operands: not taken
        drive(6'b000101, 6'd0, 5'd0, 5'd0, 16'h0003, 26'd0, 32'd0, 4'b1000);
        #1; check("bne_taken", {31'd0, taken}, 32'd0);
        step(); check("bne_pc", pc, 32'hBFC00014);

        // BLTZAL not taken still links
        drive(6'b000001, 6'd0, 5'b10000, 5'd0, 16'h0003, 26'd0, 32'd0, 4'b0100);
        #1; check("bltzal_taken", {31'd0, taken}, 32'd0);
        check("bltzal_link_en", {31'd0, link_en}, 32'd1);
        check("bltzal_link_reg", {27'd0, link_reg}, 32'd31);
        check("bltzal_link_data", link_data, 32'hBFC0001C);
        step(); check("bltzal_pc", pc, 32'hBFC00018);

        // BGEZAL taken (rs==0) with a jump in the delay slot that must be ignored
        drive(6'b000001, 6'd0, 5'b10001, 5'd0, 16'h0010, 26'd0, 32'd0, 4'b0010);
        #1; check("bgezal_taken", {31'd0, taken}, 32'd1);
        check("bgezal_link_en", {31'd0, link_en}, 32'd1);
        step(); check("bgezal_delay_pc", pc, 32'hBFC0001C);
        drive(6'b000011, 6'd0, 5'd0, 5'd0, 16'd0, 26'h0000100, 32'd0, 4'd0);
        #1; check("ds_jal_taken", {31'd0, taken}, 32'd0);
        check("ds_jal_link_en", {31'd0, link_en}, 32'd0);
        step(); check("bgezal_target_pc", pc, 32'hBFC0005C);

        // JALR rd=5 to 80001000
        drive(6'b000000, 6'b001001, 5'd0, 5'd5, 16'd0, 26'd0, 32'h80001000, 4'd0);
        #1; check("jalr_taken", {31'd0, taken}, 32'd1);
        check("jalr_link_en", {31'd0, link_en}, 32'd1);
        check("jalr_link_reg", {27'd0, link_reg}, 32'd5);
        check("jalr_link_data", link_data, 32'hBFC00064);
        step(); drive_nop();
        step(); check("jalr_target_pc", pc, 32'h80001000);

        // BLEZ taken, backward offset -4; stall in delay slot keeps target
        drive(6'b000110, 6'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'd0, 4'b0010);
        #1; check("blez_taken", {31'd0, taken}, 32'd1);
        step(); check("blez_delay_pc", pc, 32'h80001004);
        drive(6'b000010, 6'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 32'd0, 4'd0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("stall_pc", pc, 32'h80001004);
        check("stall_taken", {31'd0, taken}, 32'd0);
        stall = 1'b0;
        drive_nop();
        step(); check("blez_target_pc", pc, 32'h80001000);

        // BGTZ taken, stalled in delay slot, then async reset mid-cycle
        drive(6'b000111, 6'd0, 5'd0, 5'd0, 16'h0002, 26'd0, 32'd0, 4'b0100);
        #1; check("bgtz_taken", {31'd0, taken}, 32'd1);
        step(); check("bgtz_delay_pc", pc, 32'h80001004);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1; check("async_rst_pc", pc, 32'hBFC00000);
        check("async_rst_link_en", {31'd0, link_en}, 32'd0);
        step();
        reset = 1'b0;
        stall = 1'b0;
        drive_nop();
        step(); check("post_rst_run_pc", pc, 32'hBFC00004);

        // J keeps pc+4 upper nibble
        drive(6'b000010, 6'd0, 5'd0, 5'd0, 16'd0, 26'h0000100, 32'd0, 4'd0);
        step(); drive_nop();
        step(); check("j_target_pc", pc, 32'hB0000400);

        // JR to HALT_ADDR halts after the delay slot
        drive(6'b000000, 6'b001000, 5'd0, 5'd0, 16'd0, 26'd0, 32'h00000000, 4'd0);
        #1; check("jr_halt_taken", {31'd0, taken}, 32'd1);
        step(); drive_nop();
        step(); check("halt_pc", pc, 32'h00000000);
        check("halt_active", {31'd0, active}, 32'd0);
        drive(6'b000011, 6'd0, 5'd0, 5'd0, 16'd0, 26'h0000100, 32'd0, 4'd0);
        #1; check("halt_taken", {31'd0, taken}, 32'd0);
        check("halt_link_en", {31'd0, link_en}, 32'd0);
        step(); step(); check("halt_frozen_pc", pc, 32'h00000000);

        // Misaligned JR target
        do_reset();
        instr_valid = 1'b1;
        drive(6'b000000, 6'b001000, 5'd0, 5'd0, 16'd0, 26'd0, 32'h00000402, 4'd0);
        step(); drive_nop();
`ifdef BRANCH_ALIGN_CHECK_EN
        check("mis_addr_err", {31'd0, addr_err}, 32'd1);
        step(); check("mis_pc", pc, 32'hBFC00004);
        check("mis_active", {31'd0, active}, 32'd0);
        step(); check("mis_frozen_pc", pc, 32'hBFC00004);
`else
        check("mis_addr_err", {31'd0, addr_err}, 32'd0);
        step(); check("mis_pc", pc, 32'h00000402);
        check("mis_active", {31'd0, active}, 32'd1);
        step(); check("mis_next_pc", pc, 32'h00000406);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
